// File: rtl/vga_pkg.sv
// Shared VGA timing defaults (640x480 @ 60 Hz, 25.175 MHz pixel clock)
// and the constants derived from them.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;

    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;

    // Total length of one axis: sync + back porch + visible + front porch.
    function automatic int axis_total(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

    localparam int H_TOTAL     = axis_total(H_SYNC_DEF, H_BP_DEF, H_ACTIVE_DEF, H_FP_DEF);
    localparam int V_TOTAL     = axis_total(V_SYNC_DEF, V_BP_DEF, V_ACTIVE_DEF, V_FP_DEF);
    localparam int H_ACT_START = H_SYNC_DEF + H_BP_DEF;
    localparam int H_ACT_END   = H_ACT_START + H_ACTIVE_DEF - 1;
    localparam int V_ACT_START = V_SYNC_DEF + V_BP_DEF;
    localparam int V_ACT_END   = V_ACT_START + V_ACTIVE_DEF - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus its sync, visible-window
// and address decode. All outputs are combinational in the counter value.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int SYNC   = H_SYNC_DEF,
    parameter int BP     = H_BP_DEF,
    parameter int ACTIVE = H_ACTIVE_DEF,
    parameter int FP     = H_FP_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             wrap,
    output logic             sync_n,
    output logic             active,
    output logic [CNT_W-1:0] addr
);

    localparam int               TOTAL   = axis_total(SYNC, BP, ACTIVE, FP);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_W  = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] A_START = CNT_W'(SYNC + BP);
    localparam logic [CNT_W-1:0] A_END   = CNT_W'(SYNC + BP + ACTIVE - 1);

    logic [CNT_W-1:0] cnt;
    logic             at_last;

    assign at_last = (cnt == LAST);
    // Wrap is qualified by enable so the next axis only steps once per period.
    assign wrap    = en & at_last;

    // Position counter: steps when enabled, returns to 0 after the last slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (en)
            cnt <= at_last ? '0 : cnt + CNT_W'(1);
    end

    // Sync pulse occupies the first SYNC slots of the period, active-low.
    assign sync_n = (cnt >= SYNC_W);
    assign active = (cnt >= A_START) && (cnt <= A_END);
    assign addr   = active ? (cnt - A_START) : '0;

endmodule

// File: rtl/vga_ctrl.sv
// VGA timing generator: horizontal and vertical axis counters chained by the
// line wrap, with colour gated to the visible window. No output latency: the
// client returns vga_data for (h_addr, v_addr) in the same cycle.
module vga_ctrl
    import vga_pkg::*;
#(
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    logic h_wrap;
    logic h_active;
    logic v_active;
    logic v_wrap_unused;  // frame wrap: nothing downstream needs it

    vga_axis_counter #(
        .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP)
    ) u_h_axis (
        .clk   (pclk),
        .rst_n (reset),
        .en    (1'b1),
        .wrap  (h_wrap),
        .sync_n(hsync),
        .active(h_active),
        .addr  (h_addr)
    );

    // Vertical axis advances once per line, on the horizontal wrap cycle.
    vga_axis_counter #(
        .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP)
    ) u_v_axis (
        .clk   (pclk),
        .rst_n (reset),
        .en    (h_wrap),
        .wrap  (v_wrap_unused),
        .sync_n(vsync),
        .active(v_active),
        .addr  (v_addr)
    );

    assign valid = h_active & v_active;

    // Colour passes through only inside the visible window; black in blanking.
    assign vga_r = valid ? vga_data[23:16] : 8'h00;
    assign vga_g = valid ? vga_data[15:8]  : 8'h00;
    assign vga_b = valid ? vga_data[7:0]   : 8'h00;

endmodule

// File: tb/tb_vga_ctrl.sv
// Bench for vga_ctrl: one instance at default 640x480 timing and one shrunk
// instance that completes many frames, both checked every cycle against a
// reference timing model through a scoreboard, plus aggregate timing checks.
module tb_vga_ctrl;

    // Shrunk timing: 17 clocks per line, 11 lines per frame, 187 per frame.
    localparam int S_HS = 4, S_HB = 3, S_HA = 8, S_HF = 2, S_HT = 17;
    localparam int S_VS = 2, S_VB = 3, S_VA = 4, S_VF = 2, S_VT = 11;

    typedef struct packed {
        logic [9:0]  ha;
        logic [9:0]  va;
        logic        hs;
        logic        vs;
        logic        vl;
        logic [23:0] rgb;
    } obs_t;

    logic        pclk = 1'b0;
    logic        reset = 1'b0;
    logic [23:0] vga_data = 24'h0;

    logic [9:0] d_ha, d_va, s_ha, s_va;
    logic       d_hs, d_vs, d_vl, s_hs, s_vs, s_vl;
    logic [7:0] d_r, d_g, d_b, s_r, s_g, s_b;

    vga_ctrl u_dflt (
        .pclk(pclk), .reset(reset), .vga_data(vga_data),
        .h_addr(d_ha), .v_addr(d_va), .hsync(d_hs), .vsync(d_vs), .valid(d_vl),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b)
    );

    vga_ctrl #(
        .H_SYNC(S_HS), .H_BP(S_HB), .H_ACTIVE(S_HA), .H_FP(S_HF),
        .V_SYNC(S_VS), .V_BP(S_VB), .V_ACTIVE(S_VA), .V_FP(S_VF)
    ) u_small (
        .pclk(pclk), .reset(reset), .vga_data(vga_data),
        .h_addr(s_ha), .v_addr(s_va), .hsync(s_hs), .vsync(s_vs), .valid(s_vl),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b)
    );

    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference counters for each instance.
    int dh = 0, dv = 0, sh = 0, sv = 0;

    obs_t sb_d[$];
    obs_t sb_s[$];

    // Aggregate statistics.
    bit   hs_cnt_en = 1'b1;
    int   d_hs_low = 0;
    logic prev_dvl = 1'b0;
    logic [9:0] prev_dha = '0;
    logic prev_svs = 1'b0;
    bit   s_armed = 1'b0;
    int   s_last_fall = 0;
    int   s_low_run = 0;
    int   s_valid_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t model(input int h, input int v, input logic [23:0] d,
                                   input int hs_w, input int hbp, input int hact,
                                   input int vs_w, input int vbp, input int vact);
        obs_t o;
        bit   h_on, v_on;
        h_on  = (h >= hs_w + hbp) && (h < hs_w + hbp + hact);
        v_on  = (v >= vs_w + vbp) && (v < vs_w + vbp + vact);
        o.ha  = h_on ? 10'(h - (hs_w + hbp)) : 10'd0;
        o.va  = v_on ? 10'(v - (vs_w + vbp)) : 10'd0;
        o.hs  = (h >= hs_w);
        o.vs  = (v >= vs_w);
        o.vl  = h_on && v_on;
        o.rgb = o.vl ? d : 24'h0;
        return o;
    endfunction

    function automatic obs_t dflt_obs();
        obs_t o;
        o.ha = d_ha; o.va = d_va; o.hs = d_hs; o.vs = d_vs; o.vl = d_vl;
        o.rgb = {d_r, d_g, d_b};
        return o;
    endfunction

    function automatic obs_t small_obs();
        obs_t o;
        o.ha = s_ha; o.va = s_va; o.hs = s_hs; o.vs = s_vs; o.vl = s_vl;
        o.rgb = {s_r, s_g, s_b};
        return o;
    endfunction

    // One pixel clock: advance the model, drive data, queue expectations,
    // then compare at the falling edge.
    task automatic step();
        obs_t e_d, e_s, g_d, g_s;
        @(posedge pclk);
        if (reset) begin
            if (dh == 799) begin dh = 0; dv = (dv == 524) ? 0 : dv + 1; end
            else dh = dh + 1;
            if (sh == S_HT - 1) begin sh = 0; sv = (sv == S_VT - 1) ? 0 : sv + 1; end
            else sh = sh + 1;
        end
        #1;
        vga_data = (cyc % 4 == 3) ? 24'($urandom) : 24'h123456;
        sb_d.push_back(model(dh, dv, vga_data, 96, 48, 640, 2, 33, 480));
        sb_s.push_back(model(sh, sv, vga_data, S_HS, S_HB, S_HA, S_VS, S_VB, S_VA));
        cyc++;
        @(negedge pclk);
        e_d = sb_d.pop_front();
        e_s = sb_s.pop_front();
        g_d = dflt_obs();
        g_s = small_obs();
        chk($sformatf("dflt h=%0d v=%0d", dh, dv), g_d, e_d);
        chk($sformatf("small h=%0d v=%0d", sh, sv), g_s, e_s);

        // Default instance: sync width and visible-window edges.
        if (hs_cnt_en && !g_d.hs) d_hs_low++;
        if (g_d.vl && !prev_dvl) chk("dflt valid rise h_addr", g_d.ha, 10'd0);
        if (!g_d.vl && prev_dvl) chk("dflt valid fall last h_addr", prev_dha, 10'd639);
        prev_dvl = g_d.vl;
        prev_dha = g_d.ha;
        if (dh == 0 && dv == 35) begin
            chk("dflt v34->35 v_addr", g_d.va, 10'd0);
            chk("dflt v34->35 vsync", g_d.vs, 1'b1);
        end

        // Small instance: frame period, vsync width, visible pixel count.
        if (!g_s.vs && prev_svs) begin
            if (s_armed) begin
                chk("small frame period", cyc - s_last_fall, S_HT * S_VT);
                chk("small valid per frame", s_valid_cnt, S_HA * S_VA);
            end
            s_armed = 1'b1;
            s_last_fall = cyc;
            s_valid_cnt = 0;
            s_low_run = 0;
        end
        if (!g_s.vs) s_low_run++;
        if (g_s.vs && !prev_svs && s_armed) chk("small vsync low run", s_low_run, S_VS * S_HT);
        if (g_s.vl) s_valid_cnt++;
        prev_svs = g_s.vs;
        if (reset && sh == 0 && sv == 0) begin
            chk("small frame wrap hsync", g_s.hs, 1'b0);
            chk("small frame wrap vsync", g_s.vs, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        vga_data = 24'hFFFFFF;
        #12;
        chk("reset state dflt", dflt_obs(), 47'h0);
        chk("reset state small", small_obs(), 47'h0);
        @(negedge pclk);
        reset = 1'b1;

        // 36 full lines of default timing, many small frames in parallel.
        repeat (36 * 800) step();
        chk("dflt hsync low cycles in 36 lines", d_hs_low, 36 * 96);
        hs_cnt_en = 1'b0;

        // Move into the visible area of line 36.
        for (int i = 0; i < 1000 && dh != 300; i++) step();
        chk("dflt visible before reset", d_vl, 1'b1);

        // Asynchronous reset mid-line with white input.
        @(posedge pclk);
        #3;
        vga_data = 24'hFFFFFF;
        reset = 1'b0;
        #1;
        chk("async reset dflt", dflt_obs(), 47'h0);
        chk("async reset small", small_obs(), 47'h0);
        dh = 0; dv = 0; sh = 0; sv = 0;
        prev_dvl = 1'b0;
        prev_svs = 1'b0;
        s_armed = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        chk("reset held dflt", dflt_obs(), 47'h0);
        chk("reset held small", small_obs(), 47'h0);
        @(negedge pclk);
        reset = 1'b1;

        // Counting resumes from zero.
        repeat (900) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
